// File: rtl/display_controller_if.sv
// Valid/ready handshake carrying a signed result into the display controller.
interface display_controller_if #(
  parameter int WIDTH = 11
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;

  modport master (output in_valid, output in_value, input in_ready);
  modport slave  (input in_valid, input in_value, output in_ready);
endinterface

// File: rtl/display_controller.sv
// Converts a signed result to sign + three BCD digits (serial double-dabble)
// and commits them to registers feeding the seven-segment driver.
//
// state | meaning
// IDLE  | ready for a new value
// ABS   | take magnitude, latch sign and saturation flag
// CONV  | WIDTH shift-add-3 steps, one bit per clock
// LOAD  | commit display registers unless hold is high
module display_controller #(
  parameter int WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  display_controller_if.slave  bus,
  input  logic                 hold,
  output logic [3:0]           ones,
  output logic [3:0]           tens,
  output logic [3:0]           hundreds,
  output logic [4:0]           sign,
  output logic                 ovf,
  output logic                 busy,
  output logic                 upd
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ABS  = 2'd1;
  localparam logic [1:0] CONV = 2'd2;
  localparam logic [1:0] LOAD = 2'd3;

  // Counter is sized for the largest legal WIDTH (16 shifts).
  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  logic [1:0]       state_q;
  logic [WIDTH-1:0] shift_q;
  logic [11:0]      bcd_q;
  logic [4:0]       cnt_q;
  logic             neg_q;
  logic             sat_q;

  logic [11:0]      bcd_adj;
  logic [WIDTH-1:0] mag;
  logic             mag_big;

  // Handshake status is purely a function of the state.
  always_comb begin
    bus.in_ready = (state_q == IDLE);
    busy         = (state_q != IDLE);
  end

  // Add-3 correction per nibble and WIDTH-bit magnitude of the captured value.
  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0]  >= 4'd5) bcd_adj[3:0]  = bcd_q[3:0]  + 4'd3;
    if (bcd_q[7:4]  >= 4'd5) bcd_adj[7:4]  = bcd_q[7:4]  + 4'd3;
    if (bcd_q[11:8] >= 4'd5) bcd_adj[11:8] = bcd_q[11:8] + 4'd3;
    // Negation wraps in WIDTH bits, so the most negative input maps to 2^(WIDTH-1).
    mag = shift_q;
    if (shift_q[WIDTH-1]) mag = (~shift_q) + {{(WIDTH-1){1'b0}}, 1'b1};
    mag_big = ({{(32-WIDTH){1'b0}}, mag} > 32'd999);
  end

  // Sequencer and conversion datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            shift_q <= bus.in_value;
            state_q <= ABS;
          end
        end
        ABS: begin
          neg_q   <= shift_q[WIDTH-1];
          shift_q <= mag;
          sat_q   <= mag_big;
          bcd_q   <= '0;
          cnt_q   <= '0;
          state_q <= CONV;
        end
        CONV: begin
          // Runs full length even when saturated so latency never varies.
          bcd_q   <= {bcd_adj[10:0], shift_q[WIDTH-1]};
          shift_q <= {shift_q[WIDTH-2:0], 1'b0};
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_q == LAST) state_q <= LOAD;
        end
        default: begin
          if (!hold) state_q <= IDLE;
        end
      endcase
    end
  end

  // Display registers change only on a LOAD commit; upd flags the cycle after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ones     <= '0;
      tens     <= '0;
      hundreds <= '0;
      sign     <= '0;
      ovf      <= 1'b0;
      upd      <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (state_q == LOAD && !hold) begin
        upd  <= 1'b1;
        sign <= {4'd0, neg_q};
        ovf  <= sat_q;
        if (sat_q) begin
          ones     <= 4'd9;
          tens     <= 4'd9;
          hundreds <= 4'd9;
        end else begin
          ones     <= bcd_q[3:0];
          tens     <= bcd_q[7:4];
          hundreds <= bcd_q[11:8];
        end
      end
    end
  end

endmodule

// File: tb/tb_display_controller.sv
// Bench for display_controller: table vectors, random values against a
// decimal reference model, and hand-written hold / streaming / reset sequences.
module tb_display_controller;
  localparam int W = 11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] ones, tens, hundreds;
  logic [4:0] sign;
  logic       ovf, busy, upd;

  display_controller_if #(.WIDTH(W)) bus();

  display_controller #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .hold     (hold),
    .ones     (ones),
    .tens     (tens),
    .hundreds (hundreds),
    .sign     (sign),
    .ovf      (ovf),
    .busy     (busy),
    .upd      (upd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur_h = 0, cur_t = 0, cur_o = 0, cur_s = 0, cur_v = 0;

  typedef struct {
    int val;
    int h, t, o, s, v;
  } vec_t;

  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Decimal reference: saturate |v| at 999, split into digits.
  task automatic model(input int v, output int h, output int t, output int o,
                       output int s, output int ov);
    int m;
    m  = (v < 0) ? -v : v;
    ov = (m > 999) ? 1 : 0;
    if (ov == 1) m = 999;
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    s = (v < 0) ? 1 : 0;
  endtask

  function automatic bit disp_is(int h, int t, int o, int s, int v);
    return (int'(hundreds) == h) && (int'(tens) == t) && (int'(ones) == o) &&
           (int'(sign) == s) && (int'(ovf) == v);
  endfunction

  task automatic check_disp(input string nm, input int h, input int t, input int o,
                            input int s, input int v);
    chk({nm, ".hundreds"}, int'(hundreds), h);
    chk({nm, ".tens"},     int'(tens), t);
    chk({nm, ".ones"},     int'(ones), o);
    chk({nm, ".sign"},     int'(sign), s);
    chk({nm, ".ovf"},      int'(ovf), v);
  endtask

  // One transfer; hc = extra cycles hold is kept high in LOAD.
  task automatic run_xfer(input int v, input int h, input int t, input int o,
                          input int s, input int ov, input int hc, input string nm);
    int n;
    bit stable;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_value = W'(v);
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({nm, ".ready_wait"}, (n < 50) ? 1 : 0, 1);
    tick();                           // transfer edge E0
    bus.in_valid = 1'b0;
    bus.in_value = W'($urandom);      // must not matter after E0
    hold = (hc > 0);
    n = 0;
    stable = 1'b1;
    while (!upd && n < 100) begin
      if (!disp_is(cur_h, cur_t, cur_o, cur_s, cur_v) || bus.in_ready || !busy)
        stable = 1'b0;
      tick();
      n++;
      if (n >= 12 + hc) hold = 1'b0;
    end
    hold = 1'b0;
    chk({nm, ".stable"}, int'(stable), 1);
    chk({nm, ".latency"}, n, 13 + hc);
    check_disp(nm, h, t, o, s, ov);
    chk({nm, ".ready_at_upd"}, int'(bus.in_ready), 1);
    tick();
    chk({nm, ".upd_one_cycle"}, int'(upd), 0);
    cur_h = h; cur_t = t; cur_o = o; cur_s = s; cur_v = ov;
  endtask

  initial begin
    int h, t, o, s, ov, v, hc;
    bit ok;

    tbl[0] = '{123,   1, 2, 3, 0, 0};
    tbl[1] = '{-456,  4, 5, 6, 1, 0};
    tbl[2] = '{0,     0, 0, 0, 0, 0};
    tbl[3] = '{999,   9, 9, 9, 0, 0};
    tbl[4] = '{-1024, 9, 9, 9, 1, 1};
    tbl[5] = '{1000,  9, 9, 9, 0, 1};
    tbl[6] = '{-1,    0, 0, 1, 1, 0};
    tbl[7] = '{-999,  9, 9, 9, 1, 0};
    tbl[8] = '{1023,  9, 9, 9, 0, 1};
    tbl[9] = '{42,    0, 4, 2, 0, 0};

    bus.in_valid = 1'b0;
    bus.in_value = '0;
    hold = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    check_disp("reset_low", 0, 0, 0, 0, 0);
    chk("reset_low.upd", int'(upd), 0);
    reset = 1'b1;
    tick();
    chk("reset.in_ready", int'(bus.in_ready), 1);
    chk("reset.busy", int'(busy), 0);

    for (int i = 0; i < 10; i++)
      run_xfer(tbl[i].val, tbl[i].h, tbl[i].t, tbl[i].o, tbl[i].s, tbl[i].v, 0,
               $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 2047));
      if (v >= 1024) v -= 2048;
      hc = (i % 3 == 0) ? int'($urandom_range(1, 4)) : 0;
      model(v, h, t, o, s, ov);
      run_xfer(v, h, t, o, s, ov, hc, $sformatf("rnd%0d_v%0d", i, v));
    end

    // Hold sequence: display 42, send -7 with hold high E2..E20.
    run_xfer(42, 0, 4, 2, 0, 0, 0, "pre_hold");
    bus.in_valid = 1'b1;
    bus.in_value = W'(-7);
    tick();                             // E0
    bus.in_value = W'(300);             // second value stays pending
    ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) hold = 1'b1;
      if (!disp_is(0, 4, 2, 0, 0) || bus.in_ready || upd) ok = 1'b0;
    end
    chk("hold.frozen", int'(ok), 1);
    hold = 1'b0;
    tick();                             // E21
    check_disp("hold.commit", 0, 0, 7, 1, 0);
    chk("hold.upd", int'(upd), 1);
    bus.in_valid = 1'b0;
    cur_h = 0; cur_t = 0; cur_o = 7; cur_s = 1; cur_v = 0;
    run_xfer(300, 3, 0, 0, 0, 0, 0, "after_hold");

    // Streaming 5 then -5 with in_valid held, reset pulse at E18.
    bus.in_valid = 1'b1;
    bus.in_value = W'(5);
    tick();                             // E0
    bus.in_value = W'(-5);
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 13) begin
        check_disp("stream.first", 0, 0, 5, 0, 0);
        chk("stream.first_upd", int'(upd), 1);
        chk("stream.ready_e13", int'(bus.in_ready), 1);
      end
      if (k == 14) begin
        chk("stream.busy_e14", int'(busy), 1);
        bus.in_valid = 1'b0;
      end
    end
    reset = 1'b0;
    #1;
    check_disp("stream.reset", 0, 0, 0, 0, 0);
    chk("stream.reset_busy", int'(busy), 0);
    chk("stream.reset_upd", int'(upd), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (!disp_is(0, 0, 0, 0, 0) || upd || !bus.in_ready) ok = 1'b0;
    end
    chk("stream.lost_value", int'(ok), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
